// File: rtl/keypad_scanner_pkg.sv
// Shared types and constants for the keypad scanner slice.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        PRESS,
        HOLD
    } scanState_t;

    localparam logic [3:0] COL_INIT = 4'b1110;
    localparam logic [3:0] ROW_IDLE = 4'b1111;
    localparam int         KEY_W    = 4;

    // Key code is {column index, row index}; when several bits are low the
    // lowest index wins, which the descending loop gives for free.
    function automatic logic [KEY_W-1:0] encodeKey(input logic [3:0] cols,
                                                   input logic [3:0] rows);
        logic [1:0] colIdx;
        logic [1:0] rowIdx;
        colIdx = '0;
        rowIdx = '0;
        for (int i = 3; i >= 0; i--) begin
            if (!cols[i]) colIdx = 2'(i);
            if (!rows[i]) rowIdx = 2'(i);
        end
        return {colIdx, rowIdx};
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad pin and key-event bundle between the scanner and its neighbours.
// The master side is the scanner: it drives the column strobes and the key
// event outputs and listens to the row lines.
interface keypad_scanner_if;
    import keypad_pkg::*;

    logic [3:0]       row;
    logic [3:0]       shift_col;
    logic [KEY_W-1:0] debounced;
    logic             key_valid;
    logic             key_held;

    modport master (
        input  row,
        output shift_col,
        output debounced,
        output key_valid,
        output key_held
    );

    modport slave (
        output row,
        input  shift_col,
        input  debounced,
        input  key_valid,
        input  key_held
    );

endinterface

// File: rtl/keypad_scanner_sync_2ff.sv
// Two-flop synchronizer for slow asynchronous level inputs such as keypad rows.
module sync_2ff #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = 4'b1111
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Shift the asynchronous input through two flops, preset to the idle level.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks an active-low column strobe, debounces a
// detected press, emits one key code per physical press and tracks the hold.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 500000
) (
    input  logic             clk,
    input  logic             reset,
    keypad_scanner_if.master kp
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_CNT);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CNT - 1);

    scanState_t       state_q;
    logic [3:0]       shiftCol_q;
    logic [3:0]       shiftCol_d;
    logic [DW-1:0]    dwell_q;
    logic [CW-1:0]    cnt_q;
    logic [3:0]       rowCap_q;
    logic [KEY_W-1:0] debounced_q;
    logic [KEY_W-1:0] code_d;
    logic             keyValid_q;
    logic             keyHeld_q;
    logic [3:0]       rowS;

    sync_2ff #(
        .WIDTH     (4),
        .RESET_VAL (ROW_IDLE)
    ) u_rowSync (
        .clk     (clk),
        .reset   (reset),
        .async_i (kp.row),
        .sync_o  (rowS)
    );

    // Next column in the rotation and the code for the captured row pattern.
    always_comb begin
        shiftCol_d = {shiftCol_q[2:0], shiftCol_q[3]};
        code_d     = encodeKey(shiftCol_q, rowCap_q);
    end

    // Scan/debounce/hold state machine; every output is registered here so
    // key_valid, debounced and key_held all change on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SCAN;
            shiftCol_q  <= COL_INIT;
            dwell_q     <= '0;
            cnt_q       <= '0;
            rowCap_q    <= ROW_IDLE;
            debounced_q <= '0;
            keyValid_q  <= 1'b0;
            keyHeld_q   <= 1'b0;
        end else begin
            keyValid_q <= 1'b0;
            unique case (state_q)
                SCAN: begin
                    if (dwell_q == DWELL_LAST) begin
                        dwell_q <= '0;
                        if (rowS == ROW_IDLE) begin
                            shiftCol_q <= shiftCol_d;
                        end else begin
                            rowCap_q <= rowS;
                            cnt_q    <= '0;
                            state_q  <= DEBOUNCE;
                        end
                    end else begin
                        dwell_q <= dwell_q + DW'(1);
                    end
                end
                DEBOUNCE: begin
                    if (rowS != rowCap_q) begin
                        dwell_q <= '0;
                        cnt_q   <= '0;
                        state_q <= SCAN;
                    end else if (cnt_q == CNT_LAST) begin
                        // Outputs load on entry so they are visible during the PRESS cycle.
                        debounced_q <= code_d;
                        keyValid_q  <= 1'b1;
                        keyHeld_q   <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= PRESS;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                PRESS: begin
                    cnt_q   <= '0;
                    state_q <= HOLD;
                end
                HOLD: begin
                    if (rowS != ROW_IDLE) begin
                        cnt_q <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        keyHeld_q  <= 1'b0;
                        shiftCol_q <= shiftCol_d;
                        cnt_q      <= '0;
                        dwell_q    <= '0;
                        state_q    <= SCAN;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= SCAN;
                end
            endcase
        end
    end

    assign kp.shift_col = shiftCol_q;
    assign kp.debounced = debounced_q;
    assign kp.key_valid = keyValid_q;
    assign kp.key_held  = keyHeld_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Testbench for keypad_scanner: a behavioural keypad drives the row lines
// from the column strobes, a monitor logs every key_valid pulse, and the
// expected codes and timing come from the keypad geometry.
module tb_keypad_scanner;
    import keypad_pkg::*;

    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_CNT = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pressed;
    logic [3:0]  rowModel;
    int          cyc = 0;
    int          assertCount = 0;
    int          failCount = 0;
    int          doubleCount = 0;
    logic        prevValid = 1'b0;
    logic [3:0]  codeQ[$];
    int          cycQ[$];

    keypad_scanner_if kp();

    keypad_scanner #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .kp    (kp)
    );

    // Free-running clock and posedge counter used as a timestamp.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Keypad matrix: a pressed key pulls its row low while its column is strobed.
    always_comb begin
        rowModel = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (pressed[c*4+r] && !kp.shift_col[c]) rowModel[r] = 1'b0;
    end

    assign kp.row = rowModel;

    // Log every pulse with its timestamp and note back-to-back pulses.
    always @(negedge clk) begin
        if (kp.key_valid === 1'b1) begin
            codeQ.push_back(kp.debounced);
            cycQ.push_back(cyc);
            if (prevValid) doubleCount <= doubleCount + 1;
        end
        prevValid <= (kp.key_valid === 1'b1);
    end

    function automatic int refCode(input int c, input logic [15:0] p);
        for (int r = 0; r < 4; r++)
            if (p[c*4+r]) return c * 4 + r;
        return -1;
    endfunction

    function automatic logic [3:0] colMask(input int c);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << c);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic applyReset(input int cycles);
        reset = 1'b1;
        repeat (cycles) tick();
        reset = 1'b0;
        codeQ.delete();
        cycQ.delete();
    endtask

    task automatic waitForPulse(input string tag, input int bound,
                                output logic [3:0] code, output int pcyc);
        int n;
        n = 0;
        while (codeQ.size() == 0 && n < bound) begin
            tick();
            n++;
        end
        checkOutput({tag, "_seen"}, 32'(codeQ.size() > 0), 32'd1);
        if (codeQ.size() > 0) begin
            code = codeQ.pop_front();
            pcyc = cycQ.pop_front();
        end else begin
            code = 4'hx;
            pcyc = -1;
        end
    endtask

    task automatic waitHeldLow(input string tag, input int bound);
        int n;
        n = 0;
        while (kp.key_held !== 1'b0 && n < bound) begin
            tick();
            n++;
        end
        checkOutput(tag, 32'(kp.key_held), 32'd0);
    endtask

    // Watchdog: never let the run hang.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : applyStimulus
        logic [3:0] code;
        int         pcyc;
        int         colStart;
        int         n;
        int         k;

        pressed = '0;

        // 1: reset, idle rotation, no pulses
        applyReset(5);
        checkOutput("t1_rst_col", 32'(kp.shift_col), 32'(COL_INIT));
        checkOutput("t1_rst_code", 32'(kp.debounced), 32'd0);
        checkOutput("t1_rst_valid", 32'(kp.key_valid), 32'd0);
        checkOutput("t1_rst_held", 32'(kp.key_held), 32'd0);
        for (int i = 0; i < 4; i++) begin
            repeat (SCAN_DIV - 1) tick();
            checkOutput("t1_dwell_col", 32'(kp.shift_col), 32'(colMask(i)));
            tick();
            checkOutput("t1_rot_col", 32'(kp.shift_col), 32'(colMask((i + 1) % 4)));
        end
        checkOutput("t1_no_pulse", 32'(codeQ.size()), 32'd0);
        checkOutput("t1_code", 32'(kp.debounced), 32'd0);

        // 2: steady key col1,row2
        pressed = '0;
        pressed[6] = 1'b1;
        waitForPulse("t2", 80, code, pcyc);
        checkOutput("t2_code", 32'(code), 32'(refCode(1, pressed)));
        checkOutput("t2_held", 32'(kp.key_held), 32'd1);
        checkOutput("t2_frozen", 32'(kp.shift_col), 32'(colMask(1)));
        repeat (20) tick();
        checkOutput("t2_still_frozen", 32'(kp.shift_col), 32'(colMask(1)));
        checkOutput("t2_one_pulse", 32'(codeQ.size()), 32'd0);
        pressed = '0;
        waitHeldLow("t2_release", 40);
        checkOutput("t2_next_col", 32'(kp.shift_col), 32'(colMask(2)));

        // 3: bouncing press and release of col0,row0
        codeQ.delete();
        cycQ.delete();
        for (int i = 0; i < 10; i++) begin
            pressed[0] = ~pressed[0];
            repeat (2) tick();
        end
        checkOutput("t3_bounce_quiet", 32'(codeQ.size()), 32'd0);
        pressed[0] = 1'b1;
        waitForPulse("t3", 80, code, pcyc);
        checkOutput("t3_code", 32'(code), 32'(refCode(0, pressed)));
        for (int i = 0; i < 10; i++) begin
            pressed[0] = ~pressed[0];
            repeat (2) tick();
        end
        checkOutput("t3_held_bounce", 32'(kp.key_held), 32'd1);
        pressed = '0;
        waitHeldLow("t3_release", 40);
        repeat (10) tick();
        checkOutput("t3_no_extra", 32'(codeQ.size()), 32'd0);

        // 4: two rows in col3, then a col0 key while held
        pressed = '0;
        pressed[13] = 1'b1;
        pressed[15] = 1'b1;
        waitForPulse("t4", 80, code, pcyc);
        checkOutput("t4_code", 32'(code), 32'(refCode(3, pressed)));
        pressed[0] = 1'b1;
        repeat (20) tick();
        checkOutput("t4_no_rollover", 32'(codeQ.size()), 32'd0);
        pressed = '0;
        waitHeldLow("t4_release", 40);
        pressed[0] = 1'b1;
        waitForPulse("t4b", 80, code, pcyc);
        checkOutput("t4b_code", 32'(code), 32'(refCode(0, pressed)));
        pressed = '0;
        waitHeldLow("t4b_release", 40);

        // 5: sweep every key in code order with latency check
        for (int kk = 0; kk < 16; kk++) begin
            n = 0;
            while (kp.shift_col == colMask(kk / 4) && n < 50) begin
                tick();
                n++;
            end
            pressed = 16'(1) << kk;
            n = 0;
            while (kp.shift_col != colMask(kk / 4) && n < 50) begin
                tick();
                n++;
            end
            colStart = cyc;
            waitForPulse("t5", 40, code, pcyc);
            checkOutput("t5_code", 32'(code), 32'(kk));
            checkOutput("t5_latency", 32'(pcyc), 32'(colStart + SCAN_DIV + DEBOUNCE_CNT));
            pressed = '0;
            waitHeldLow("t5_release", 40);
        end

        // 6: reset during hold with col2,row1 still down
        pressed = '0;
        pressed[9] = 1'b1;
        waitForPulse("t6", 80, code, pcyc);
        checkOutput("t6_code", 32'(code), 32'(refCode(2, pressed)));
        repeat (3) tick();
        applyReset(1);
        checkOutput("t6_rst_col", 32'(kp.shift_col), 32'(COL_INIT));
        checkOutput("t6_rst_code", 32'(kp.debounced), 32'd0);
        checkOutput("t6_rst_held", 32'(kp.key_held), 32'd0);
        checkOutput("t6_rst_valid", 32'(kp.key_valid), 32'd0);
        waitForPulse("t6b", 80, code, pcyc);
        checkOutput("t6b_code", 32'(code), 32'(refCode(2, pressed)));
        pressed = '0;
        waitHeldLow("t6_release", 40);

        // 7: random keys with random hold and gap times
        for (int i = 0; i < 12; i++) begin
            k = int'($urandom_range(0, 15));
            pressed = 16'(1) << k;
            waitForPulse("t7", 80, code, pcyc);
            checkOutput("t7_code", 32'(code), 32'(refCode(k / 4, pressed)));
            repeat ($urandom_range(2, 30)) tick();
            checkOutput("t7_held", 32'(kp.key_held), 32'd1);
            pressed = '0;
            waitHeldLow("t7_release", 40);
            repeat ($urandom_range(0, 10)) tick();
            checkOutput("t7_no_extra", 32'(codeQ.size()), 32'd0);
        end

        checkOutput("no_double_valid", 32'(doubleCount), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
